displ_7_segs_multi: RTL

Multi-digit seven-segment display controller for the board's hex displays. It latches an N-digit hex value with per-digit decimal points, applies optional leading-zero blanking and whole-display blinking, and drives two registered outputs. The first is a static bus with all digits in parallel, for the DE10-Lite HEX0–HEX5. The second is a time-multiplexed scan port with an active-low digit select, for common-anode modules. It sits between the CPU's memory-mapped I/O register and the top-level HEX pins.

---
 rtl/displ_pkg.sv | 29 ++
 rtl/dig_displ_7_segs.sv | 30 +++
 rtl/displ_7_segs_multi.sv | 106 ++++++++++
 3 files changed

// File: rtl/displ_pkg.sv
// Shared constants and helpers for the multi-digit seven-segment display controller.
package displ_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int unsigned MAX_DIGITS = 8;

    // Bit i set means digit i is a leading zero that may be blanked; digit 0 is never blanked.
    // A nonzero digit or a lit dp stops blanking for itself and every digit below it.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input logic [MAX_DIGITS-1:0]   dp,
        input int unsigned             num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  keep;
        mask = '0;
        keep = 1'b0;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if ((MAX_DIGITS - 1 - k) < num_digits) begin
                if (value[4*(MAX_DIGITS-1-k) +: 4] != 4'h0 || dp[MAX_DIGITS-1-k])
                    keep = 1'b1;
                if ((MAX_DIGITS - 1 - k) != 0)
                    mask[MAX_DIGITS-1-k] = ~keep;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/dig_displ_7_segs.sv
// Single hex digit to active-low seven-segment decoder (segments g..a, dp handled by caller).
module dig_displ_7_segs (
    input  logic [3:0] digit,
    output logic [6:0] segs
);

    always_comb begin
        segs = 7'h7F;
        case (digit)
            4'h0: segs = 7'h40;
            4'h1: segs = 7'h79;
            4'h2: segs = 7'h24;
            4'h3: segs = 7'h30;
            4'h4: segs = 7'h19;
            4'h5: segs = 7'h12;
            4'h6: segs = 7'h02;
            4'h7: segs = 7'h78;
            4'h8: segs = 7'h00;
            4'h9: segs = 7'h10;
            4'hA: segs = 7'h08;
            4'hB: segs = 7'h03;
            4'hC: segs = 7'h46;
            4'hD: segs = 7'h21;
            4'hE: segs = 7'h06;
            4'hF: segs = 7'h0E;
            default: segs = 7'h7F;
        endcase
    end

endmodule

// File: rtl/displ_7_segs_multi.sv
// Multi-digit hex display driver: static all-digit bus plus a time-multiplexed scan port,
// with leading-zero blanking and whole-display blinking.
module displ_7_segs_multi
    import displ_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [8*NUM_DIGITS-1:0] segs,
    output logic [7:0]              scan_segs,
    output logic [NUM_DIGITS-1:0]   scan_sel
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        scan_idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic                    tick;

    logic [6:0]              dec [NUM_DIGITS];
    logic [7:0]              pat [NUM_DIGITS];
    logic [8*NUM_DIGITS-1:0] pat_bus;
    logic [MAX_DIGITS-1:0]   lz_full;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        dig_displ_7_segs u_dig (
            .digit (value_q[4*g +: 4]),
            .segs  (dec[g])
        );
    end

    assign tick    = (prescaler == PRE_LAST);
    assign lz_full = lz_mask(32'(value_q), 8'(dp_q), NUM_DIGITS);

    // Blink overrides everything, including a lit dp.
    always_comb begin
        pat_bus = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            pat[i] = {~dp_q[i], dec[i]};
            if (blank_lz && lz_full[i])
                pat[i] = SEG_BLANK;
            if (blink_en && blink_phase)
                pat[i] = SEG_BLANK;
            pat_bus[8*i +: 8] = pat[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q     <= '0;
            dp_q        <= '0;
            prescaler   <= '0;
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            segs        <= '1;
            scan_segs   <= SEG_BLANK;
            scan_sel    <= '1;
        end else begin
            if (en) begin
                value_q <= value;
                dp_q    <= dp;
            end

            prescaler <= tick ? '0 : prescaler + 1'b1;

            if (tick)
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;

            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (tick) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            segs      <= pat_bus;
            scan_segs <= pat[scan_idx];
            scan_sel  <= ~(NUM_DIGITS'(1) << scan_idx);
        end
    end

endmodule
